// File: rtl/bot_upd_scheduler.sv
// -----------------------------------------------------------------------------
// bot_upd_scheduler
//
// Turns the register-update events of two rojobots (A and B) into a single
// CPU interrupt. Each event marks its bot pending; an FSM raises irq for one
// pending bot at a time and waits for the CPU acknowledge (or an optional
// timeout). When both bots are pending, the bot not served last goes next.
//
// Optional feature (macro BOT_UPD_SYNC_EN):
//   defined   : each upd input passes through a 2-flop synchronizer and a
//               rising-edge detector. A held level counts as one event, and
//               latency grows by 2 cycles.
//   undefined : upd inputs are used directly. Every cycle sampled high is
//               one event.
//
// Parameters
//   ACK_TIMEOUT : cycles SERVE waits for int_ack before abandoning (0 = off)
//   CNT_W       : timeout counter width; ACK_TIMEOUT-1 must fit
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   upd_a       in   bot A register-update event
//   upd_b       in   bot B register-update event
//   int_ack     in   CPU acknowledge (level)
//   clr_err     in   one-cycle pulse, clears overrun / timeout_err
//   irq         out  update-pending interrupt (registered)
//   irq_src     out  bot being served, 0 = A, 1 = B (valid while irq=1)
//   pending     out  per-bot pending flags, [0] = A, [1] = B
//   overrun     out  sticky per-bot flag: event arrived while already pending
//   timeout_err out  sticky flag: acknowledge timeout occurred
// -----------------------------------------------------------------------------
module bot_upd_scheduler #(
  parameter int ACK_TIMEOUT = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       upd_a,
  input  logic       upd_b,
  input  logic       int_ack,
  input  logic       clr_err,
  output logic       irq,
  output logic       irq_src,
  output logic [1:0] pending,
  output logic [1:0] overrun,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SERVE   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam bit               TO_EN   = (ACK_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(ACK_TIMEOUT - 1) : '0;

  // Per-bot event strobes, bit 0 = A, bit 1 = B.
  logic [1:0] ev;

`ifdef BOT_UPD_SYNC_EN
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {upd_b, upd_a};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Rising edge of the synchronized level: a held input is a single event.
  assign ev = sync2_q & ~prev_q;
`else
  assign ev = {upd_b, upd_a};
`endif

  state_t           state_q, state_d;
  logic             irq_q, irq_d;
  logic             src_q, src_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       ovr_q, ovr_d;
  logic             to_q, to_d;

  logic [1:0]       clr_bits;
  logic             to_hit;
  logic             sel;

  // Round-robin pick: a lone pending bot wins; with both pending, the bot
  // that was not served last goes next.
  assign sel = (pend_q == 2'b11) ? ~last_q : pend_q[1];

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    src_d    = src_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    clr_bits = 2'b00;
    to_hit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_q != 2'b00) begin
          src_d   = sel;
          irq_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        if (int_ack || (TO_EN && (cnt_q == TO_LAST))) begin
          // Acknowledge and timeout retire the served bot the same way;
          // only a timeout without ack raises the error flag.
          to_hit   = ~int_ack;
          clr_bits = src_q ? 2'b10 : 2'b01;
          last_d   = src_q;
          irq_d    = 1'b0;
          state_d  = S_RELEASE;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        // Wait for ack to drop so a held ack cannot retire a second bot.
        if (!int_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        irq_d   = 1'b0;
      end
    endcase

    // A new event re-arms a bot even as it is being retired; it only counts
    // as an overrun when the bot stays pending from before.
    pend_d = (pend_q & ~clr_bits) | ev;
    ovr_d  = (clr_err ? 2'b00 : ovr_q) | (ev & pend_q & ~clr_bits);
    to_d   = (clr_err ? 1'b0 : to_q) | to_hit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      irq_q   <= 1'b0;
      src_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      pend_q  <= 2'b00;
      ovr_q   <= 2'b00;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      src_q   <= src_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  assign irq         = irq_q;
  assign irq_src     = src_q;
  assign pending     = pend_q;
  assign overrun     = ovr_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_bot_upd_scheduler.sv
module tb_bot_upd_scheduler;

  localparam int TO = 8;

  logic       clock;
  logic       reset;
  logic       upd_a;
  logic       upd_b;
  logic       int_ack;
  logic       clr_err;
  logic       irq;
  logic       irq_src;
  logic [1:0] pending;
  logic [1:0] overrun;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  bot_upd_scheduler #(
    .ACK_TIMEOUT(TO),
    .CNT_W      (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .upd_a      (upd_a),
    .upd_b      (upd_b),
    .int_ack    (int_ack),
    .clr_err    (clr_err),
    .irq        (irq),
    .irq_src    (irq_src),
    .pending    (pending),
    .overrun    (overrun),
    .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Reference model: tracks which bot is being served, when service began
  // (absolute edge number), and whether we are waiting for ack to drop.
  // ---------------------------------------------------------------------------
  bit       m_serving, m_waitrel, m_src, m_last, m_to;
  bit [1:0] m_pend, m_ovr;
  bit [1:0] h1, h2, h3;
  int       cyc, m_entry;

  task automatic model_edge();
    bit [1:0] ev;
    bit [1:0] retired;
    bit       tmo;
    cyc++;
`ifdef BOT_UPD_SYNC_EN
    ev = h2 & ~h3;
    if (reset) begin
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      h3 = h2; h2 = h1; h1 = {upd_b, upd_a};
    end
`else
    ev = {upd_b, upd_a};
`endif
    if (reset) begin
      m_serving = 0; m_waitrel = 0; m_src = 0; m_last = 1;
      m_pend = 0; m_ovr = 0; m_to = 0;
      return;
    end
    retired = 0;
    tmo     = 0;
    if (m_waitrel) begin
      if (!int_ack) m_waitrel = 0;
    end else if (m_serving) begin
      if (int_ack || (cyc - m_entry == TO)) begin
        tmo = !int_ack;
        retired[m_src] = 1'b1;
        m_last    = m_src;
        m_serving = 0;
        m_waitrel = 1;
      end
    end else if (m_pend != 0) begin
      if (m_pend == 2'b11) m_src = !m_last;
      else                 m_src = (m_pend == 2'b10);
      m_serving = 1;
      m_entry   = cyc;
    end
    m_ovr  = (clr_err ? 2'b00 : m_ovr) | (ev & m_pend & ~retired);
    m_to   = (clr_err ? 1'b0 : m_to) | tmo;
    m_pend = (m_pend & ~retired) | ev;
  endtask

  function automatic logic [6:0] model_vec();
    return {m_serving, m_src, m_pend, m_ovr, m_to};
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic reset_dut();
    reset = 1; upd_a = 0; upd_b = 0; int_ack = 0; clr_err = 0;
    step();
    step();
    reset = 0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_dut();
    total++; if (irq !== 1'b0)         begin bad++; $display("FAIL rst_irq got=%0b want=0", irq); end
    total++; if (irq_src !== 1'b0)     begin bad++; $display("FAIL rst_src got=%0b want=0", irq_src); end
    total++; if (pending !== 2'b00)    begin bad++; $display("FAIL rst_pending got=%b want=00", pending); end
    total++; if (overrun !== 2'b00)    begin bad++; $display("FAIL rst_overrun got=%b want=00", overrun); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%0b want=0", timeout_err); end
  endtask

`ifndef BOT_UPD_SYNC_EN
  task automatic test_single();
    reset_dut();
    upd_a = 1; step();
    total++; if (pending !== 2'b01) begin bad++; $display("FAIL single_pend got=%b want=01", pending); end
    total++; if (irq !== 1'b0)      begin bad++; $display("FAIL single_early_irq got=%0b want=0", irq); end
    upd_a = 0; step();
    total++; if ({irq, irq_src} !== 2'b10) begin bad++; $display("FAIL single_irq got=%b want=10", {irq, irq_src}); end
    step(); step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL single_hold got=%0b want=1", irq); end
    int_ack = 1; step();
    total++; if ({irq, pending} !== 3'b000) begin bad++; $display("FAIL single_ack got=%b want=000", {irq, pending}); end
    int_ack = 0; step(); step();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL single_idle got=%0b want=0", irq); end
  endtask

  task automatic test_arbitration();
    reset_dut();
    for (int round = 0; round < 2; round++) begin
      upd_a = 1; upd_b = 1; step();
      upd_a = 0; upd_b = 0; step();
      total++; if ({irq, irq_src} !== 2'b10) begin bad++; $display("FAIL arb_first r%0d got=%b want=10", round, {irq, irq_src}); end
      int_ack = 1; step();
      total++; if (pending !== 2'b10) begin bad++; $display("FAIL arb_pend r%0d got=%b want=10", round, pending); end
      int_ack = 0; step(); step();
      total++; if ({irq, irq_src} !== 2'b11) begin bad++; $display("FAIL arb_second r%0d got=%b want=11", round, {irq, irq_src}); end
      int_ack = 1; step();
      total++; if (pending !== 2'b00) begin bad++; $display("FAIL arb_done r%0d got=%b want=00", round, pending); end
      int_ack = 0; step();
    end
  endtask

  task automatic test_overrun();
    reset_dut();
    upd_b = 1; step();
    upd_b = 0; step();
    step();
    upd_b = 1; step();
    upd_b = 0;
    total++; if ({pending[1], overrun} !== 3'b110) begin bad++; $display("FAIL ovr_set got=%b want=110", {pending[1], overrun}); end
    clr_err = 1; step();
    clr_err = 0;
    total++; if (overrun !== 2'b00) begin bad++; $display("FAIL ovr_clear got=%b want=00", overrun); end
  endtask

  task automatic test_timeout();
    int n;
    reset_dut();
    upd_a = 1; step();
    upd_a = 0; step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL to_entry got=%0b want=1", irq); end
    n = 0;
    while (irq === 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++; if (n !== TO) begin bad++; $display("FAIL to_cycles got=%0d want=%0d", n, TO); end
    total++; if ({timeout_err, pending} !== 3'b100) begin bad++; $display("FAIL to_flags got=%b want=100", {timeout_err, pending}); end
    clr_err = 1; step();
    clr_err = 0;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear got=%0b want=0", timeout_err); end
  endtask

  task automatic test_held_ack();
    reset_dut();
    upd_a = 1; upd_b = 1; step();
    upd_a = 0; upd_b = 0; step();
    int_ack = 1; step();
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if ({irq, pending} !== 3'b010) begin bad++; $display("FAIL held_ack_c%0d got=%b want=010", i, {irq, pending}); end
    end
    int_ack = 0; step(); step();
    total++; if ({irq, irq_src} !== 2'b11) begin bad++; $display("FAIL held_ack_next got=%b want=11", {irq, irq_src}); end
  endtask

  task automatic test_reset_serve();
    reset_dut();
    upd_a = 1; step();
    upd_a = 0; step();
    reset = 1; upd_b = 1; step();
    reset = 0; upd_b = 0;
    total++; if ({irq, irq_src, pending, overrun, timeout_err} !== 7'b0) begin
      bad++; $display("FAIL rst_serve got=%b want=0000000", {irq, irq_src, pending, overrun, timeout_err});
    end
  endtask
`else
  task automatic test_sync_level();
    int first;
    reset_dut();
    first = -1;
    upd_a = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (irq === 1'b1 && first < 0) first = i;
    end
    upd_a = 0;
    total++; if (first !== 3) begin bad++; $display("FAIL sync_latency got=%0d want=3", first); end
    total++; if (overrun !== 2'b00) begin bad++; $display("FAIL sync_overrun got=%b want=00", overrun); end
  endtask
`endif

  task automatic test_random();
    logic [6:0] exp_v;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      upd_a   = ($urandom_range(0, 3) == 0);
      upd_b   = ($urandom_range(0, 3) == 0);
      clr_err = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) int_ack = ~int_ack;
      step();
      exp_v = model_vec();
      total++;
      if ({irq, irq_src, pending, overrun, timeout_err} !== exp_v) begin
        bad++;
        $display("FAIL random_c%0d got=%b want=%b", i, {irq, irq_src, pending, overrun, timeout_err}, exp_v);
      end
    end
    reset = 0; upd_a = 0; upd_b = 0; int_ack = 0; clr_err = 0;
  endtask

  initial begin
    reset = 1; upd_a = 0; upd_b = 0; int_ack = 0; clr_err = 0;
    test_reset();
`ifndef BOT_UPD_SYNC_EN
    test_single();
    test_arbitration();
    test_overrun();
    test_timeout();
    test_held_ack();
    test_reset_serve();
`else
    test_sync_level();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bot_upd_scheduler.md
BOT_UPD_SCHEDULER -- requirements
Module: bot_upd_scheduler

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 1000000, meaning the number of cycles SERVE waits for int_ack before abandoning (0 = timeout disabled).
REQ-002 SHALL have parameter CNT_W, default 20, meaning the width of the timeout counter; ACK_TIMEOUT-1 SHALL fit in CNT_W bits.
REQ-003 SHALL have port clock, input, 1 bit: the single system clock; every register in the block is clocked by its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port upd_a, input, 1 bit: bot A register-update event (upd_sysregs of rojobot A).
REQ-006 SHALL have port upd_b, input, 1 bit: bot B register-update event.
REQ-007 SHALL have port int_ack, input, 1 bit: CPU acknowledge, a level signal.
REQ-008 SHALL have port clr_err, input, 1 bit: one-cycle pulse that clears the sticky error flags.
REQ-009 SHALL have port irq, output, 1 bit: update-pending interrupt to the CPU GPIO.
REQ-010 SHALL have port irq_src, output, 1 bit: bot being served (0 = A, 1 = B); valid whenever irq=1.
REQ-011 SHALL have port pending, output, 2 bits: per-bot pending flags, [0] = A, [1] = B.
REQ-012 SHALL have port overrun, output, 2 bits: sticky flag per bot, set when a new event arrives while that bot is already pending.
REQ-013 SHALL have port timeout_err, output, 1 bit: sticky flag set when an ack timeout occurs.

Function
REQ-014 SHALL treat each upd input as an event when it is sampled high (a pulse); in the synchronized build (REQ-028) an event is the detected rising edge.
REQ-015 SHALL set pending[i] on the clock edge that samples event i.
REQ-016 SHALL, when event i is sampled while pending[i]=1, keep pending[i]=1 and set overrun[i], unless pending[i] is being cleared on that same edge; in that case pending[i] stays 1 and overrun[i] is not set.
REQ-017 SHALL implement an FSM with states IDLE, SERVE and RELEASE.
REQ-018 IDLE: if pending!=0, SHALL select a source, register irq_src, drive irq=1 and go to SERVE; otherwise SHALL stay in IDLE with irq=0.
REQ-019 Selection: if exactly one bit of pending is set, that source; if both are set, the source other than last_src (last_src is the previously served source, reset value 1, so A wins first).
REQ-020 SERVE: irq SHALL remain 1 and irq_src stable until exit; on int_ack=1 SHALL clear pending[irq_src], update last_src, drop irq to 0 and go to RELEASE.
REQ-021 SERVE timeout (ACK_TIMEOUT>0): the counter SHALL start at 0 on SERVE entry and increment each cycle; if it reaches ACK_TIMEOUT-1 with int_ack=0, SHALL set timeout_err, clear pending[irq_src], update last_src, drop irq and go to RELEASE.
REQ-022 RELEASE: SHALL return to IDLE when int_ack=0, ignoring pending while in RELEASE; a held int_ack SHALL NOT acknowledge a second source.
REQ-023 Latency: an event sampled at edge N sets pending at N; with the FSM in IDLE, irq=1 SHALL be registered at edge N+1.
REQ-024 clr_err SHALL clear overrun and timeout_err on the next edge; an overrun or timeout occurring on that same edge SHALL win (flag set).
REQ-025 SHALL register every output; no combinational path from any input to any output.

Reset
REQ-026 While reset=1 at a rising edge, the block SHALL set: state=IDLE, irq=0, irq_src=0, pending=0, overrun=0, timeout_err=0, counter=0, last_src=1, and clear the synchronizer flops.
REQ-027 Reset asserted mid-SERVE SHALL abandon the service with no timeout_err set; events sampled while reset=1 SHALL be discarded.

Configuration
REQ-028 With macro BOT_UPD_SYNC_EN defined, each upd input SHALL pass through a 2-flop synchronizer plus a rising-edge detector, giving 2 extra cycles of latency; a level held high counts as one event.
REQ-029 Without BOT_UPD_SYNC_EN, upd inputs SHALL be used directly per REQ-014, and a level held for k cycles counts as k events.

Verification (default build, ACK_TIMEOUT=8 unless noted)
REQ-030 upd_a pulse at edge 5, int_ack=1 at edge 9 -> pending=01 at 5, irq=1/irq_src=0 at 6, irq=0 and pending=00 at 9, state IDLE one cycle after int_ack falls.
REQ-031 upd_a and upd_b both pulsed at edge 3, each acked in turn -> served A first then B; pulse both again -> A first again, since last_src=B.
REQ-032 upd_b pulsed twice, 2 cycles apart, with no ack -> pending[1]=1, overrun=10; clr_err pulse -> overrun=00.
REQ-033 upd_a pulse, never acked -> irq drops and timeout_err=1 exactly 8 cycles after SERVE entry, pending=00.
REQ-034 int_ack held high across two pending sources -> second irq only after int_ack falls; reset during SERVE -> all outputs 0 on the next edge.
REQ-035 BOT_UPD_SYNC_EN build: upd_a held high for 10 cycles -> single event, irq at edge N+3, overrun=00.
